// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 decryption datapath stages (init, KSA, PRGA).
// Holds the S memory geometry, default key length and the KSA state encoding.
package arc4_pkg;

    localparam int unsigned S_DEPTH           = 256;
    localparam int unsigned S_AW              = 8;
    localparam int unsigned KEY_BYTES_DEFAULT = 3;
    localparam int unsigned KEY_W_DEFAULT     = 8 * KEY_BYTES_DEFAULT;

    typedef enum logic [3:0] {
        KsaIdle,
        KsaRdIA,
        KsaRdIB,
        KsaJUpd,
        KsaRdJA,
        KsaRdJB,
        KsaWrI,
        KsaWrJ,
        KsaNext,
        KsaDone
    } ksa_state_t;

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes S in place using the latched key.
// Eight cycles per iteration: read S[i], update j, read S[j], write both back.
module ksa
    import arc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [S_AW-1:0]        s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren
);

    localparam int unsigned     KIW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIW-1:0]  KIDX_LAST = KIW'(KEY_BYTES - 1);
    localparam logic [S_AW-1:0] I_LAST    = S_AW'(S_DEPTH - 1);

    ksa_state_t             state_q, state_d;
    logic [S_AW-1:0]        i_q, j_q;
    logic [7:0]             si_q, sj_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [KIW-1:0]         kidx_q;
    logic [7:0]             key_byte;

    // Byte 0 of the key sits in the most significant byte.
    always_comb begin
        key_byte = '0;
        for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KIW'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= KsaIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q    <= '0;
            j_q    <= '0;
            si_q   <= '0;
            sj_q   <= '0;
            key_q  <= '0;
            kidx_q <= '0;
        end else begin
            case (state_q)
                KsaIdle: begin
                    if (en) begin
                        key_q  <= key;
                        i_q    <= '0;
                        j_q    <= '0;
                        kidx_q <= '0;
                    end
                end
                KsaRdIB: si_q <= s_rddata;
                KsaJUpd: j_q  <= j_q + si_q + key_byte;
                KsaRdJB: sj_q <= s_rddata;
                KsaNext: begin
                    if (i_q != I_LAST) begin
                        i_q    <= i_q + 1'b1;
                        kidx_q <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        rdy      = 1'b0;
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (state_q)
            KsaIdle: begin
                rdy = 1'b1;
                if (en) state_d = KsaRdIA;
            end
            KsaRdIA: begin
                s_addr  = i_q;
                state_d = KsaRdIB;
            end
            KsaRdIB: begin
                s_addr  = i_q;
                state_d = KsaJUpd;
            end
            KsaJUpd: state_d = KsaRdJA;
            KsaRdJA: begin
                s_addr  = j_q;
                state_d = KsaRdJB;
            end
            KsaRdJB: begin
                s_addr  = j_q;
                state_d = KsaWrI;
            end
            KsaWrI: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = KsaWrJ;
            end
            KsaWrJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = KsaNext;
            end
            KsaNext: state_d = (i_q == I_LAST) ? KsaDone : KsaRdIA;
            KsaDone: state_d = KsaIdle;
            default: state_d = KsaIdle;
        endcase
    end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: behavioural S RAM plus a software ARC4 KSA/PRGA reference.
// Random and directed keys, mid-run disturbances, reset mid-run, back-to-back runs.
module tb_ksa;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr;
    logic [7:0]  s_rddata;
    logic [7:0]  s_wrdata;
    logic        s_wren;
    logic        do_init;

    logic [7:0] mem     [256];
    logic [7:0] model_s [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ksa dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rdy      (rdy),
        .key      (key),
        .s_addr   (s_addr),
        .s_rddata (s_rddata),
        .s_wrdata (s_wrdata),
        .s_wren   (s_wren)
    );

    // Synchronous RAM with 1-cycle read latency; do_init emulates the init stage.
    always @(posedge clk) begin
        if (do_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (s_wren) begin
            mem[s_addr] <= s_wrdata;
        end
        s_rddata <= mem[s_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_ksa(input logic [23:0] k);
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb [3];
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) model_s[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = j + model_s[n] + kb[n % 3];
            t = model_s[n];
            model_s[n] = model_s[j];
            model_s[j] = t;
        end
    endtask

    task automatic chk_s(input string tag);
        int bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== model_s[n]) bad++;
        chk(tag, bad, 0);
    endtask

    // PRGA on a copy of the RAM contents left by the DUT.
    task automatic chk_prga(input logic [31:0] exp);
        logic [7:0]  s [256];
        logic [7:0]  pi, pj, t;
        logic [31:0] ks;
        for (int n = 0; n < 256; n++) s[n] = mem[n];
        pi = 0;
        pj = 0;
        ks = 0;
        for (int n = 0; n < 4; n++) begin
            pi = pi + 1;
            pj = pj + s[pi];
            t = s[pi];
            s[pi] = s[pj];
            s[pj] = t;
            ks = {ks[23:0], s[8'(s[pi] + s[pj])]};
        end
        chk("prga_keystream", ks, exp);
    endtask

    // Entered at a negedge with rdy expected high; leaves at a negedge.
    // mode 0: plain; 1: en pulse and key change at cycle 100; 2: reset at cycle 1000.
    task automatic run_ksa(input logic [23:0] k, input int mode, input logic init,
                           output int busy, output int nwr,
                           output logic [15:0] w0, output logic [15:0] w1);
        busy = -1;
        nwr  = 0;
        w0   = 'x;
        w1   = 'x;
        chk("accept_rdy", 32'(rdy), 1);
        key     = k;
        en      = 1'b1;
        do_init = init;
        @(posedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                en      = 1'b0;
                do_init = 1'b0;
                chk("busy_after_accept", 32'(rdy), 0);
            end
            if (rdy) begin
                busy = cyc;
                break;
            end
            if (mode == 1 && cyc == 100) begin
                en  = 1'b1;
                key = ~k;
            end
            if (mode == 1 && cyc == 101) en = 1'b0;
            if (mode == 2 && cyc == 1000) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("midrst_rdy", 32'(rdy), 1);
                chk("midrst_wren", 32'(s_wren), 0);
                rst = 1'b0;
                for (int q = 0; q < 4; q++) begin
                    @(negedge clk);
                    chk("postrst_wren", 32'(s_wren), 0);
                end
                chk("postrst_rdy", 32'(rdy), 1);
                return;
            end
            if (s_wren) begin
                if (nwr == 0) w0 = {s_addr, s_wrdata};
                if (nwr == 1) w1 = {s_addr, s_wrdata};
                nwr++;
            end
            @(posedge clk);
        end
        if (busy < 0) chk("run_timeout", 0, 1);
    endtask

    initial begin
        int          busy, nwr;
        logic [15:0] w0, w1;
        logic [23:0] rk;

        rst     = 1'b1;
        en      = 1'b0;
        key     = '0;
        do_init = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_rdy", 32'(rdy), 1);
            chk("idle_wren", 32'(s_wren), 0);
            chk("idle_addr", 32'(s_addr), 0);
        end

        // All-zero key: first iteration is a self-swap at address 0.
        run_ksa(24'h000000, 0, 1'b1, busy, nwr, w0, w1);
        chk("k0_busy", busy, 2049);
        chk("k0_writes", nwr, 512);
        chk("k0_first_wr", 32'(w0), 32'h0000);
        chk("k0_second_wr", 32'(w1), 32'h0000);
        model_ksa(24'h000000);
        chk_s("k0_s");

        run_ksa(24'h4B6579, 0, 1'b1, busy, nwr, w0, w1);
        chk("key_busy", busy, 2049);
        chk("key_writes", nwr, 512);
        model_ksa(24'h4B6579);
        chk_s("key_s");
        chk_prga(32'hEB9F7781);

        run_ksa(24'h4B6579, 1, 1'b1, busy, nwr, w0, w1);
        chk("disturb_busy", busy, 2049);
        chk_s("disturb_s");

        for (int r = 0; r < 3; r++) begin
            rk = 24'($urandom);
            run_ksa(rk, 0, 1'b1, busy, nwr, w0, w1);
            chk("rand_busy", busy, 2049);
            chk("rand_writes", nwr, 512);
            model_ksa(rk);
            chk_s("rand_s");
        end

        run_ksa(24'h4B6579, 2, 1'b1, busy, nwr, w0, w1);
        @(negedge clk);
        run_ksa(24'h4B6579, 0, 1'b1, busy, nwr, w0, w1);
        chk("after_rst_busy", busy, 2049);
        model_ksa(24'h4B6579);
        chk_s("after_rst_s");
        chk_prga(32'hEB9F7781);

        // Back-to-back: second run starts on the same cycle rdy returns.
        run_ksa(24'h000001, 0, 1'b1, busy, nwr, w0, w1);
        chk("b2b1_busy", busy, 2049);
        model_ksa(24'h000001);
        chk_s("b2b1_s");
        run_ksa(24'h123456, 0, 1'b1, busy, nwr, w0, w1);
        chk("b2b2_busy", busy, 2049);
        chk("b2b2_writes", nwr, 512);
        model_ksa(24'h123456);
        chk_s("b2b2_s");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ksa.md
# ksa

Key-scheduling stage of the ARC4 decryption datapath. Runs the 256-iteration ARC4 key-scheduling permutation in place on the shared 256×8 S memory. S must already hold the identity permutation, written by the init stage. On completion S is ready for the downstream PRGA stage, which consumes it with the same 24-bit key and the same `en`/`rdy` handshake.

## Interface
Parameters:
- `KEY_BYTES`, default 3: key length in bytes; key width is `8*KEY_BYTES`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: start request; honoured only while `rdy`=1.
- `rdy` out 1: block idle and able to accept `en`.
- `key` in `8*KEY_BYTES`: cipher key. Byte 0 is the MSB byte (`key[23:16]` for 3 bytes). Sampled on the `en` acceptance edge and held internally.
- `s_addr` out 8: S memory address.
- `s_rddata` in 8: S memory read data. Synchronous RAM, 1-cycle read latency.
- `s_wrdata` out 8: S memory write data.
- `s_wren` out 1: S memory write enable.

## Operation
- Computes, for i = 0..255:
  - j = (j + S[i] + key[i mod KEY_BYTES]) mod 256
  - then swap S[i] and S[j].
- i and j start at 0 on every run.
- All arithmetic is 8-bit wraparound; carries are discarded.
- `i mod KEY_BYTES` comes from a wrapping byte-index counter (0..KEY_BYTES-1), not a divider. The counter resets to 0 on each start.
- States:
  - IDLE: `rdy`=1. On `en`=1: latch key, clear i, j and the byte index; go to RD_I_A.
  - RD_I_A: `s_addr`=i; go to RD_I_B.
  - RD_I_B: `s_addr`=i; capture `si` ← `s_rddata` at the end of the cycle; go to J_UPD.
  - J_UPD: j ← j + si + keybyte; go to RD_J_A.
  - RD_J_A: `s_addr`=j; go to RD_J_B.
  - RD_J_B: `s_addr`=j; capture `sj` at the end of the cycle; go to WR_I.
  - WR_I: `s_addr`=i, `s_wrdata`=sj, `s_wren`=1; go to WR_J.
  - WR_J: `s_addr`=j, `s_wrdata`=si, `s_wren`=1; go to NEXT.
  - NEXT: if i==255 go to DONE. Otherwise i ← i+1, advance the byte index, and go to RD_I_A.
  - DONE: go to IDLE.
- `rdy` = (state == IDLE), decoded from registered state.
- `s_wren` is high only in WR_I and WR_J.
- In all other states `s_wren`=0, and `s_addr`/`s_wrdata` are driven to 0 wherever the list above does not define them.
- `en` while busy is ignored; a request is never queued.
- `key` changes while busy have no effect.
- i == j (self-swap): both writes go to the same address with the same value. S is unchanged. No special case.
- Read after write: the next iteration reads S[i] two or more cycles after the WR_J write, so it sees the updated value. The RAM needs no bypass.

## Timing
- Reset values: `rdy`=1, `s_wren`=0, `s_addr`=0, `s_wrdata`=0. State goes to IDLE; i, j and the byte index go to 0.
- Reset mid-run: IDLE on the next cycle, with no further writes. S is left partially permuted; the controller must re-run init.
- Call the `en` acceptance edge E0.
  - `rdy` is 0 from the cycle after E0.
  - Each iteration takes 8 cycles.
  - DONE is occupied after edge E0+2048.
  - `rdy` returns to 1 after edge E0+2049.
  - Total busy time is 2049 cycles.
- Exactly 512 write cycles per run.
- The last write (S[j] for i=255) is in cycle E0+2047.
- A new `en` is accepted in the first cycle `rdy`=1; back-to-back runs have no extra gap.

## Structure
- Shared package `arc4_pkg` holds:
  - the `ksa_state_t` enum;
  - `S_DEPTH`=256 and `S_AW`=8;
  - the default key width.
- The package is shared with the init and PRGA stages.
- No sub-module. The key-byte mux and index counter are small enough to stay inline.
- One FSM (`always_ff` state register plus `always_comb` next-state/output decode) plus datapath registers i, j, si, sj, key_q, kidx.

## Test plan
- Reset, then hold `en`=0 for 10 cycles -> `rdy`=1, `s_wren`=0 and `s_addr`=0 throughout.
- Identity S, key 0x000000:
  - first two writes are (addr 0, data 0) twice (self-swap);
  - `rdy` high again exactly 2049 cycles after acceptance;
  - 512 write cycles counted.
- Identity S, key 0x4B6579 ("Key"):
  - final S matches the golden software KSA model byte for byte;
  - chaining to PRGA gives keystream EB 9F 77 81.
- Pulse `en` again at cycle 100 of a run, and change `key` mid-run -> ignored; final S identical to the undisturbed run.
- Assert `rst` at cycle 1000 of a run -> `rdy`=1 and `s_wren`=0 from the next cycle. A following init plus KSA run with key 0x4B6579 yields the golden S.
- Two back-to-back runs, keys 0x000001 then 0x123456, re-initialising S between them -> each final S matches the model; the second `en` is accepted on the first `rdy`=1 cycle.
